// File: rtl/mcu_dmi_mbox_pkg.sv
// Shared constants for the DMI command mailbox.
//   - Register offsets relative to BASE_ADDR
//   - STATUS bit indices
//   - Mailbox FSM state type
package mcu_dmi_mbox_pkg;

  localparam logic [2:0] OFF_CMD    = 3'd0;
  localparam logic [2:0] OFF_ARG    = 3'd1;
  localparam logic [2:0] OFF_RESP   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_CLEAR  = 3'd4;
  localparam logic [7:0] NUM_REGS   = 8'd5;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_AERR = 2;
  localparam int ST_OERR = 3;
  localparam int ST_TERR = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/mcu_dmi_mbox_timer.sv
// Response timeout counter for the DMI mailbox (built only with
// MCU_DMI_MBOX_TIMEOUT_EN).
//   clk, rst_n : core clock, async active-low reset
//   start      : command launch; clears the count for the coming REQ cycle
//   run        : FSM is in REQ or WAIT
//   expired    : run and count has reached TIMEOUT_CYCLES-1
`ifdef MCU_DMI_MBOX_TIMEOUT_EN
module mcu_dmi_mbox_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (start) cnt <= '0;
    else if (run)   cnt <= cnt + 1'b1;
  end

  assign expired = run && (cnt == LAST);

endmodule
`endif

// File: rtl/mcu_dmi_mbox_responder.sv
// Core-clock DMI register target exposing a one-command-at-a-time mailbox
// toward an MCU-side agent (req/ack handshake).
// Optional feature macro: MCU_DMI_MBOX_TIMEOUT_EN (response timeout).
// Ports:
//   core_clk, core_rst_n      : clock, async active-low reset
//   reg_en, reg_wr_en         : one-cycle DMI access strobe / write qualifier
//   reg_wr_addr, reg_wr_data  : DMI address and write data
//   rd_data                   : registered read data, held between reads
//   mbox_req, mbox_req_cmd,
//   mbox_req_data             : command request to agent (stable while req)
//   mbox_ack, mbox_resp_data,
//   mbox_resp_err             : one-cycle completion from agent
module mcu_dmi_mbox_responder
  import mcu_dmi_mbox_pkg::*;
#(
  parameter logic [6:0] BASE_ADDR      = 7'h50,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        reg_en,
  input  logic        reg_wr_en,
  input  logic [6:0]  reg_wr_addr,
  input  logic [31:0] reg_wr_data,
  output logic [31:0] rd_data,
  output logic        mbox_req,
  output logic [31:0] mbox_req_cmd,
  output logic [31:0] mbox_req_data,
  input  logic        mbox_ack,
  input  logic [31:0] mbox_resp_data,
  input  logic        mbox_resp_err
);

  state_e      state, state_d;
  logic [31:0] arg, resp;
  logic        done, agent_err, overrun_err, timeout_err;
  logic        busy, launch, ack_hit, tmo, overrun, expired;
  logic [7:0]  off_full;
  logic        hit;
  logic [2:0]  off;
  logic        rd_stb, wr_stb, cmd_wr, arg_wr, clr_wr;
  logic [4:0]  clr;
  logic [31:0] status;

  // 8-bit difference: addresses below BASE_ADDR wrap to >= 129, so one
  // compare covers both range ends.
  assign off_full = {1'b0, reg_wr_addr} - {1'b0, BASE_ADDR};
  assign hit      = off_full < NUM_REGS;
  assign off      = off_full[2:0];

  assign rd_stb = reg_en && !reg_wr_en;
  assign wr_stb = reg_en && reg_wr_en && hit;
  assign cmd_wr = wr_stb && (off == OFF_CMD);
  assign arg_wr = wr_stb && (off == OFF_ARG);
  assign clr_wr = wr_stb && (off == OFF_CLEAR);
  assign clr    = clr_wr ? reg_wr_data[4:0] : 5'd0;

  assign busy   = (state != S_IDLE);
  assign status = {27'd0, timeout_err, overrun_err, agent_err, done, busy};

`ifdef MCU_DMI_MBOX_TIMEOUT_EN
  mcu_dmi_mbox_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (core_clk),
    .rst_n   (core_rst_n),
    .start   (launch),
    .run     (busy),
    .expired (expired)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) state <= S_IDLE;
    else             state <= state_d;
  end

  always_comb begin
    state_d = state;
    launch  = 1'b0;
    ack_hit = 1'b0;
    tmo     = 1'b0;
    overrun = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_wr) begin
          launch  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        // A CMD write while busy is dropped, even alongside the ack.
        overrun = cmd_wr;
        if (mbox_ack) begin
          ack_hit = 1'b1;
          state_d = S_IDLE;
        end else if (expired) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // mbox_req is registered off the next state so it is glitch-free across
  // the REQ->WAIT encoding change and drops with the async reset.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      mbox_req      <= 1'b0;
      mbox_req_cmd  <= '0;
      mbox_req_data <= '0;
    end else begin
      mbox_req <= (state_d != S_IDLE);
      if (launch) begin
        mbox_req_cmd  <= reg_wr_data;
        mbox_req_data <= arg;
      end
    end
  end

  // Sticky status bits: clear first, then set, so a set in the same
  // cycle as a CLEAR wins.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      arg         <= '0;
      resp        <= '0;
      done        <= 1'b0;
      agent_err   <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (arg_wr)  arg  <= reg_wr_data;
      if (ack_hit) resp <= mbox_resp_data;
      done        <= launch ? 1'b0 : ((done && !clr[ST_DONE]) || ack_hit);
      agent_err   <= (agent_err && !clr[ST_AERR]) || (ack_hit && mbox_resp_err);
      overrun_err <= (overrun_err && !clr[ST_OERR]) || overrun;
      timeout_err <= (timeout_err && !clr[ST_TERR]) || tmo;
    end
  end

  // Read data loads pre-edge register values, so a RESP read in the ack
  // cycle returns the old response.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      rd_data <= '0;
    end else if (rd_stb) begin
      if (!hit) begin
        rd_data <= '0;
      end else begin
        case (off)
          OFF_ARG:    rd_data <= arg;
          OFF_RESP:   rd_data <= resp;
          OFF_STATUS: rd_data <= status;
          default:    rd_data <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcu_dmi_mbox_responder.sv
// Self-checking bench for mcu_dmi_mbox_responder: directed scenarios then
// randomized DMI traffic and agent acks against a transaction-level model.
module tb_mcu_dmi_mbox_responder;

  localparam logic [6:0] BASE = 7'h50;
  localparam int         TMO  = 16;

  logic        core_clk = 1'b0;
  logic        core_rst_n;
  logic        reg_en, reg_wr_en;
  logic [6:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] rd_data;
  logic        mbox_req;
  logic [31:0] mbox_req_cmd, mbox_req_data;
  logic        mbox_ack;
  logic [31:0] mbox_resp_data;
  logic        mbox_resp_err;

  always #5 core_clk = ~core_clk;

  mcu_dmi_mbox_responder #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .core_clk       (core_clk),
    .core_rst_n     (core_rst_n),
    .reg_en         (reg_en),
    .reg_wr_en      (reg_wr_en),
    .reg_wr_addr    (reg_wr_addr),
    .reg_wr_data    (reg_wr_data),
    .rd_data        (rd_data),
    .mbox_req       (mbox_req),
    .mbox_req_cmd   (mbox_req_cmd),
    .mbox_req_data  (mbox_req_data),
    .mbox_ack       (mbox_ack),
    .mbox_resp_data (mbox_resp_data),
    .mbox_resp_err  (mbox_resp_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: mailbox as a set of plain variables.
  logic [31:0] m_arg, m_resp, m_cmd, m_data, m_rd;
  bit          m_busy, m_done, m_aerr, m_oerr, m_terr;
  int          m_age;

  function automatic void m_reset();
    m_arg = 0; m_resp = 0; m_cmd = 0; m_data = 0; m_rd = 0;
    m_busy = 0; m_done = 0; m_aerr = 0; m_oerr = 0; m_terr = 0; m_age = 0;
  endfunction

  function automatic logic [31:0] m_status();
    return {27'd0, m_terr, m_oerr, m_aerr, m_done, m_busy};
  endfunction

  function automatic void m_step(bit en, bit wr, logic [6:0] a, logic [31:0] d,
                                 bit ack, logic [31:0] rdat, bit rerr);
    int off;
    bit hit, launch, acked, tmo, ovr;
    logic [4:0] c;
    off = int'(a) - int'(BASE);
    hit = (off >= 0) && (off < 5);
    launch = 0; acked = 0; tmo = 0; ovr = 0; c = 0;
    if (en && !wr) begin
      if (!hit)          m_rd = 0;
      else if (off == 1) m_rd = m_arg;
      else if (off == 2) m_rd = m_resp;
      else if (off == 3) m_rd = m_status();
      else               m_rd = 0;
    end
    if (m_busy && ack) acked = 1;
`ifdef MCU_DMI_MBOX_TIMEOUT_EN
    else if (m_busy) begin
      if (m_age == TMO - 1) tmo = 1;
      else m_age++;
    end
`endif
    if (en && wr && hit) begin
      case (off)
        0: if (m_busy) ovr = 1; else launch = 1;
        1: m_arg = d;
        4: c = d[4:0];
        default: ;
      endcase
    end
    if (acked) m_resp = rdat;
    m_done = launch ? 1'b0 : ((m_done && !c[1]) || acked);
    m_aerr = (m_aerr && !c[2]) || (acked && rerr);
    m_oerr = (m_oerr && !c[3]) || ovr;
    m_terr = (m_terr && !c[4]) || tmo;
    if (acked || tmo) m_busy = 0;
    if (launch) begin
      m_busy = 1; m_cmd = d; m_data = m_arg; m_age = 0;
    end
  endfunction

  // One clock: drive, clock, advance the model, compare every output.
  task automatic cyc(input bit en, input bit wr, input logic [6:0] a, input logic [31:0] d,
                     input bit ack, input logic [31:0] rdat, input bit rerr);
    reg_en = en; reg_wr_en = wr; reg_wr_addr = a; reg_wr_data = d;
    mbox_ack = ack; mbox_resp_data = rdat; mbox_resp_err = rerr;
    @(posedge core_clk);
    #1;
    m_step(en, wr, a, d, ack, rdat, rerr);
    reg_en = 0; reg_wr_en = 0; mbox_ack = 0;
    chk("mbox_req", {31'd0, mbox_req}, {31'd0, m_busy});
    chk("req_cmd", mbox_req_cmd, m_cmd);
    chk("req_data", mbox_req_data, m_data);
    chk("rd_data", rd_data, m_rd);
  endtask

  task automatic idle();            cyc(0, 0, 7'h0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [6:0] a, input logic [31:0] d); cyc(1, 1, a, d, 0, 0, 0); endtask
  task automatic rd(input logic [6:0] a);                        cyc(1, 0, a, 0, 0, 0, 0); endtask

  logic [31:0] saved;
  int          n;

  initial begin
    m_reset();
    core_rst_n = 0; reg_en = 0; reg_wr_en = 0; reg_wr_addr = 0; reg_wr_data = 0;
    mbox_ack = 0; mbox_resp_data = 0; mbox_resp_err = 0;
    #12;
    chk("rst_req", {31'd0, mbox_req}, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    core_rst_n = 1;

    // Reset status read.
    rd(BASE + 7'd3);
    chk("status_rst", rd_data, 32'h0);

    // Basic command with ack three cycles after launch.
    wr(BASE + 7'd1, 32'hCAFE0001);
    wr(BASE + 7'd0, 32'h7);
    chk("launch_cmd", mbox_req_cmd, 32'h7);
    chk("launch_data", mbox_req_data, 32'hCAFE0001);
    idle(); idle();
    cyc(0, 0, 7'h0, 0, 1, 32'h12345678, 0);
    chk("req_drop", {31'd0, mbox_req}, 32'd0);
    rd(BASE + 7'd3);
    chk("status_done", rd_data, 32'h2);
    rd(BASE + 7'd2);
    chk("resp", rd_data, 32'h12345678);

    // Overrun while busy, then clear it.
    wr(BASE + 7'd0, 32'h9);
    wr(BASE + 7'd0, 32'hAA);
    chk("ovr_cmd_kept", mbox_req_cmd, 32'h9);
    rd(BASE + 7'd3);
    chk("status_ovr", rd_data, 32'h9);
    wr(BASE + 7'd4, 32'h8);
    rd(BASE + 7'd3);
    chk("status_clr", rd_data, 32'h1);

    // Error ack with a same-cycle CLEAR of agent_err: set wins.
    cyc(1, 1, BASE + 7'd4, 32'h4, 1, 32'h55, 1);
    rd(BASE + 7'd3);
    chk("status_aerr", rd_data, 32'h6);
    // Ack while idle is ignored.
    cyc(0, 0, 7'h0, 0, 1, 32'hDEAD, 1);
    rd(BASE + 7'd2);
    chk("idle_ack_resp", rd_data, 32'h55);
    wr(BASE + 7'd4, 32'h1E);

`ifdef MCU_DMI_MBOX_TIMEOUT_EN
    wr(BASE + 7'd0, 32'h3);
    n = 0;
    while (mbox_req && n < 40) begin idle(); n++; end
    chk("tmo_cycles", n, TMO);
    rd(BASE + 7'd3);
    chk("status_tmo", rd_data, 32'h10);
    rd(BASE + 7'd2);
    saved = rd_data;
    cyc(0, 0, 7'h0, 0, 1, 32'hBEEF, 0);
    rd(BASE + 7'd2);
    chk("tmo_late_ack", rd_data, saved);
    wr(BASE + 7'd4, 32'h1E);
`endif

    // Reset in WAIT drops the request without a clock edge.
    wr(BASE + 7'd0, 32'h11);
    idle(); idle();
    #2 core_rst_n = 0;
    #1 chk("async_rst_req", {31'd0, mbox_req}, 32'd0);
    m_reset();
    #3 core_rst_n = 1;
    rd(BASE + 7'd3);
    chk("status_post_rst", rd_data, 32'h0);
    wr(BASE + 7'd0, 32'h22);
    chk("relaunch", {31'd0, mbox_req}, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int op;
      bit ak;
      logic [6:0] a;
      op = $urandom_range(0, 5);
      ak = ($urandom_range(0, 3) == 0);
      a  = 7'($urandom_range(int'(BASE) - 2, int'(BASE) + 6));
      case (op)
        0: cyc(0, 0, a, $urandom, ak, $urandom, 1'($urandom));
        1: cyc(1, 0, a, $urandom, ak, $urandom, 1'($urandom));
        2: cyc(1, 1, BASE + 7'd1, $urandom, ak, $urandom, 1'($urandom));
        3: cyc(1, 1, BASE + 7'd0, $urandom, ak, $urandom, 1'($urandom));
        4: cyc(1, 1, BASE + 7'd4, $urandom, ak, $urandom, 1'($urandom));
        default: cyc(1, 0, BASE + 7'd3, 0, ak, $urandom, 1'($urandom));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
